rf_wb_sched: RTL and testbench

Write-port scheduler and scoreboard for the 32x32 register file (two async read ports, one write port, x0 hard-wired to zero). It shares the single RF write port between the in-order pipeline WB stage and a long-latency unit (mul/div, load-miss return). It tracks registers with an outstanding long-latency result so that ID can interlock. It also forces a one-cycle pipeline bubble when the long-latency unit has been starved of the write port.

---
 rtl/rf_wb_sched.sv | 101 ++++++++++
 tb/tb_rf_wb_sched.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
`default_nettype none
// ============================================================================
// rf_wb_sched : RF write-port arbiter (WB over long-latency unit), pending-
//               destination scoreboard and LU starvation bubble request.
// Revision    : 1.0
// ============================================================================
module rf_wb_sched #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_addr,
   output logic        iss_ready,
   input  logic [4:0]  chk1_addr,
   input  logic [4:0]  chk2_addr,
   output logic        chk1_busy,
   output logic        chk2_busy,
   output logic [4:0]  rf_wraddr,
   output logic [31:0] rf_wrdata,
   output logic        rf_wren,
   output logic        pipe_stall
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] C_WAIT_MAX  = CW'(STARVE_MAX);
   localparam logic [CW-1:0] C_WAIT_TRIG = CW'(STARVE_MAX - 1);

   logic [31:0]   pend_q, pend_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          pipe_stall_q, pipe_stall_d;
   logic          lu_xfer;
   logic          lu_lost;
   logic          iss_fire;

   // WB cannot be back-pressured, so it always owns the port when valid.
   always_comb begin
      lu_ready  = 1'b0;
      rf_wraddr = lu_addr;
      rf_wrdata = lu_data;
      rf_wren   = 1'b0;
      if (wb_valid) begin
         rf_wraddr = wb_addr;
         rf_wrdata = wb_data;
         rf_wren   = ~rst & (wb_addr != 5'd0);
      end else begin
         lu_ready  = ~rst & lu_valid;
         rf_wren   = ~rst & lu_valid & (lu_addr != 5'd0);
      end
   end

   assign lu_xfer   = lu_valid & lu_ready;
   assign lu_lost   = lu_valid & ~lu_ready;
   assign iss_ready = ~rst & ~pend_q[iss_addr];
   assign iss_fire  = iss_valid & iss_ready & (iss_addr != 5'd0);
   assign chk1_busy = ~rst & pend_q[chk1_addr];
   assign chk2_busy = ~rst & pend_q[chk2_addr];
   assign pipe_stall = pipe_stall_q;

   // Clear is applied first so a same-cycle issue to the same register wins.
   always_comb begin
      pend_d = pend_q;
      if (lu_xfer) begin
         pend_d[lu_addr] = 1'b0;
      end
      if (iss_fire) begin
         pend_d[iss_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_comb begin
      wait_cnt_d   = '0;
      pipe_stall_d = 1'b0;
      if (lu_lost) begin
         wait_cnt_d   = (wait_cnt_q == C_WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
         pipe_stall_d = pipe_stall_q | (wait_cnt_q == C_WAIT_TRIG);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q       <= '0;
         wait_cnt_q   <= '0;
         pipe_stall_q <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         wait_cnt_q   <= wait_cnt_d;
         pipe_stall_q <= pipe_stall_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_sched : vector-table bench for rf_wb_sched with an RF-write
//                  scoreboard.
// Revision       : 1.0
// ============================================================================
module tb_rf_wb_sched;

   typedef struct {
      logic        rst;
      logic        wbv;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        luv;
      logic [4:0]  lua;
      logic [31:0] lud;
      logic        issv;
      logic [4:0]  issa;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        e_lur;
      logic        e_issr;
      logic        e_b1;
      logic        e_b2;
      logic        e_stall;
      logic        e_wren;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, lu_valid, iss_valid;
   logic [4:0]  wb_addr, lu_addr, iss_addr, chk1_addr, chk2_addr;
   logic [31:0] wb_data, lu_data;
   logic        lu_ready, iss_ready, chk1_busy, chk2_busy, rf_wren, pipe_stall;
   logic [4:0]  rf_wraddr;
   logic [31:0] rf_wrdata;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [36:0] exp_q[$];
   vec_t        vecs[$];

   always #5 clk = ~clk;

   rf_wb_sched #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
      .chk1_busy(chk1_busy), .chk2_busy(chk2_busy),
      .rf_wraddr(rf_wraddr), .rf_wrdata(rf_wrdata), .rf_wren(rf_wren),
      .pipe_stall(pipe_stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Pops the scoreboard whenever the DUT writes the RF; an unexpected or
   // missing write shows up as an rf_wren miscompare.
   task automatic check_rf();
      logic [36:0] e;
      chk("rf_wren", {31'd0, rf_wren}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rf_wren) begin
            chk("rf_wraddr", {27'd0, rf_wraddr}, {27'd0, e[36:32]});
            chk("rf_wrdata", rf_wrdata, e[31:0]);
         end
      end
   endtask

   // Drive at posedge+1, compare at the falling edge, then advance one cycle.
   task automatic apply(input vec_t v, input string tag);
      rst = v.rst;
      wb_valid = v.wbv;  wb_addr = v.wba;  wb_data = v.wbd;
      lu_valid = v.luv;  lu_addr = v.lua;  lu_data = v.lud;
      iss_valid = v.issv; iss_addr = v.issa;
      chk1_addr = v.c1;  chk2_addr = v.c2;
      if (v.e_wren) exp_q.push_back(v.wbv ? {v.wba, v.wbd} : {v.lua, v.lud});
      #4;
      chk({tag, " lu_ready"},   {31'd0, lu_ready},   {31'd0, v.e_lur});
      chk({tag, " iss_ready"},  {31'd0, iss_ready},  {31'd0, v.e_issr});
      chk({tag, " chk1_busy"},  {31'd0, chk1_busy},  {31'd0, v.e_b1});
      chk({tag, " chk2_busy"},  {31'd0, chk2_busy},  {31'd0, v.e_b2});
      chk({tag, " pipe_stall"}, {31'd0, pipe_stall}, {31'd0, v.e_stall});
      check_rf();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t lu_wb(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                                  input logic luv, input logic lur, input logic stall,
                                  input logic wren);
      return vec_t'{1'b0, wbv, wba, wbd, luv, 5'd20, 32'h0000ABCD, 1'b0, 5'd0, 5'd0, 5'd0,
                    lur, 1'b1, 1'b0, 1'b0, stall, wren};
   endfunction

   initial begin
      rst = 1'b1;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
      iss_valid = 1'b0; iss_addr = '0; chk1_addr = '0; chk2_addr = '0;

      //                rst wbv wba    wbd           luv lua    lud           issv issa   c1     c2     lur issr b1  b2  stl wren
      vecs.push_back(vec_t'{1, 1, 5'd3, 32'h11,       1, 5'd7, 32'h22,       1, 5'd5, 5'd5, 5'd7, 0, 0, 0, 0, 0, 0});
      vecs.push_back(vec_t'{1, 1, 5'd3, 32'h11,       1, 5'd7, 32'h22,       1, 5'd5, 5'd5, 5'd7, 0, 0, 0, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd5, 0, 1, 0, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0, 1, 1, 1, 0, 0, 1});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 0, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{0, 1, 5'd3, 32'h11,       1, 5'd7, 32'h22,       0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 1});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        1, 5'd7, 32'h22,       0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 1});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 5'd0, 0, 0, 1, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd0, 5'd0, 5'd9, 0, 1, 0, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h55,       0, 5'd0, 5'd0, 5'd9, 1, 1, 0, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        1, 5'd12, 32'h77,      1, 5'd12, 5'd0, 5'd0, 1, 1, 0, 0, 0, 1});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd12, 5'd9, 0, 1, 1, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h99,       0, 5'd0, 5'd0, 5'd9, 1, 1, 0, 1, 0, 1});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd12, 5'd9, 0, 1, 1, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd15, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{1, 0, 5'd0, 32'h0,        1, 5'd15, 32'h33,      0, 5'd15, 5'd15, 5'd0, 0, 0, 0, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd15, 5'd15, 5'd12, 0, 1, 0, 0, 0, 0});

      @(posedge clk);
      #1;
      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Starvation with a non-compliant WB: stall rises after 4 lost cycles and
      // holds while WB keeps winning, then clears once lu_valid drops.
      for (int k = 0; k < 6; k++)
         apply(lu_wb(1'b1, 5'd1, 32'(k), 1'b1, 1'b0, k >= 4, 1'b1), $sformatf("starveA%0d", k));
      apply(lu_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0), "starveA_drop");
      apply(lu_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), "starveA_idle");

      // Compliant pipeline: WB yields in the stall cycle and the LU transfers.
      for (int k = 0; k < 4; k++)
         apply(lu_wb(1'b1, 5'd2, 32'h100 + 32'(k), 1'b1, 1'b0, 1'b0, 1'b1), $sformatf("starveB%0d", k));
      apply(lu_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1), "starveB_xfer");
      apply(lu_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), "starveB_after");

      // Counter must restart after a transfer: 3 more lost cycles stay bubble-free.
      for (int k = 0; k < 3; k++)
         apply(lu_wb(1'b1, 5'd4, 32'h200 + 32'(k), 1'b1, 1'b0, 1'b0, 1'b1), $sformatf("starveC%0d", k));
      apply(lu_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1), "starveC_xfer");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
